// File: rtl/subleq_pkg.sv
// State encoding shared by the SUBLEQ control FSM, datapath and PC incrementer.
package subleq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH_A     = 4'd0,
        LOAD_A      = 4'd1,
        FETCH_B     = 4'd2,
        LOAD_B      = 4'd3,
        FETCH_C     = 4'd4,
        LOAD_C      = 4'd5,
        FETCH_MEM_A = 4'd6,
        LOAD_MEM_A  = 4'd7,
        FETCH_MEM_B = 4'd8,
        LOAD_MEM_B  = 4'd9,
        EXECUTE     = 4'd10,
        WRITEBACK   = 4'd11,
        UPDATE_PC   = 4'd12,
        HALT        = 4'd13,
        IDLE        = 4'd14
    } state_t;

endpackage

// File: rtl/subleq_wait_timer.sv
// Memory wait-state counter: while run_i is high it counts 0..LIMIT and flags done
// on the final count; it returns to zero as soon as run_i drops or done is reached.
module subleq_wait_timer #(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic done_o
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == CW'(LIMIT));

    always_comb begin
        cnt_d = '0;
        if (run_i && !done_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/subleq_control.sv
// SUBLEQ control FSM: sequences fetch/load/execute/writeback/update-pc with run/stop/halt
// control, memory wait states and a saturating retired-instruction counter.
module subleq_control
    import subleq_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned MAX_INSTR = 0,
    parameter int          CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               zero,
    input  logic               negative,
    output logic               a_ld,
    output logic               b_ld,
    output logic               c_ld,
    output logic               mem_a_ld,
    output logic               mem_b_ld,
    output logic               result_ld,
    output logic               mem_read,
    output logic               mem_write,
    output logic               pc_ld,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           state_q, state_d;
    logic             stop_pend_q, stop_pend_d;
    logic             branch_q, branch_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             is_fetch, idle_or_halt, timer_done, wait_done, max_hit;

    assign is_fetch     = state_q inside {FETCH_A, FETCH_B, FETCH_C, FETCH_MEM_A, FETCH_MEM_B};
    assign idle_or_halt = (state_q == IDLE) || (state_q == HALT);
    assign count_inc    = (&count_q) ? count_q : count_q + CNT_W'(1);
    assign max_hit      = (MAX_INSTR != 0) && (count_inc == CNT_W'(MAX_INSTR));

    subleq_wait_timer #(.LIMIT(MEM_WAIT)) u_wait_timer (
        .clk_i  (clk),
        .rst_i  (rst),
        .run_i  (is_fetch),
        .done_o (timer_done)
    );

    assign wait_done = (MEM_WAIT == 0) ? 1'b1 : timer_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT:  if (start) state_d = FETCH_A;
            FETCH_A:     if (wait_done) state_d = LOAD_A;
            LOAD_A:      state_d = FETCH_B;
            FETCH_B:     if (wait_done) state_d = LOAD_B;
            LOAD_B:      state_d = FETCH_C;
            FETCH_C:     if (wait_done) state_d = LOAD_C;
            LOAD_C:      state_d = FETCH_MEM_A;
            FETCH_MEM_A: if (wait_done) state_d = LOAD_MEM_A;
            LOAD_MEM_A:  state_d = FETCH_MEM_B;
            FETCH_MEM_B: if (wait_done) state_d = LOAD_MEM_B;
            LOAD_MEM_B:  state_d = EXECUTE;
            EXECUTE:     state_d = WRITEBACK;
            WRITEBACK:   state_d = UPDATE_PC;
            UPDATE_PC:   state_d = (stop_pend_q || max_hit) ? HALT : FETCH_A;
            default:     state_d = IDLE;
        endcase
    end

    // Start from IDLE/HALT wins over a simultaneous stop; a pending stop dies on entering HALT.
    always_comb begin
        stop_pend_d = stop_pend_q;
        branch_d    = branch_q;
        count_d     = count_q;
        if (idle_or_halt) begin
            if (start) begin
                stop_pend_d = 1'b0;
                count_d     = '0;
            end
        end else if (stop) begin
            stop_pend_d = 1'b1;
        end
        if (state_q == EXECUTE) branch_d = zero | negative;
        if (state_q == UPDATE_PC) count_d = count_inc;
        if (state_d == HALT) stop_pend_d = 1'b0;
    end

    always_comb begin
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        c_ld      = 1'b0;
        mem_a_ld  = 1'b0;
        mem_b_ld  = 1'b0;
        result_ld = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_ld     = 1'b0;
        halted    = 1'b0;
        case (state_q)
            FETCH_A, FETCH_B, FETCH_C, FETCH_MEM_A, FETCH_MEM_B: mem_read = 1'b1;
            LOAD_A:     begin mem_read = 1'b1; a_ld     = 1'b1; end
            LOAD_B:     begin mem_read = 1'b1; b_ld     = 1'b1; end
            LOAD_C:     begin mem_read = 1'b1; c_ld     = 1'b1; end
            LOAD_MEM_A: begin mem_read = 1'b1; mem_a_ld = 1'b1; end
            LOAD_MEM_B: begin mem_read = 1'b1; mem_b_ld = 1'b1; end
            EXECUTE:    result_ld = 1'b1;
            WRITEBACK:  mem_write = 1'b1;
            UPDATE_PC:  pc_ld     = branch_q;
            HALT:       halted    = 1'b1;
            default:    ;
        endcase
    end

    assign busy        = !idle_or_halt;
    assign state       = state_q;
    assign instr_count = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
            branch_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            branch_q    <= branch_d;
            count_q     <= count_d;
        end
    end

endmodule
